// File: rtl/div_pkg.sv
// Shared types and constants for the rca_div8x4 restoring divider.
// Holds the FSM state enum, default widths and counter width.
package div_pkg;

  localparam int DIV_DW = 8;
  localparam int DIV_VW = 4;
  localparam int CNT_W  = $clog2(DIV_DW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/rca_div8x4_if.sv
// Start/busy/done handshake bundle for rca_div8x4.
// master drives the request, slave returns the result.
interface rca_div8x4_if
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) ();

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient,
    input  remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient,
    output remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a bit,
// ripple-carry trial subtract, restore on borrow.
module div_step
  import div_pkg::*;
#(
  parameter int VW = DIV_VW
) (
  input  logic [VW:0]   r,
  input  logic          bin,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   r_nxt,
  output logic          qbit
);

  logic [VW:0]   sh;
  logic [VW:0]   sub;
  logic [VW:0]   diff;
  logic [VW+1:0] c;
  logic          unused_msb;

  // R never exceeds the divisor, so its top bit is always clear
  assign unused_msb = r[VW];
  assign sh  = {r[VW-1:0], bin};
  assign sub = ~{1'b0, divisor};

  // sh + ~d + 1 as an explicit ripple chain; carry out = no borrow
  always_comb begin
    c    = '0;
    diff = '0;
    c[0] = 1'b1;
    for (int i = 0; i <= VW; i++) begin
      diff[i]  = sh[i] ^ sub[i] ^ c[i];
      c[i+1]   = (sh[i] & sub[i])
               | (c[i] & (sh[i] ^ sub[i]));
    end
  end

  assign qbit  = c[VW+1];
  assign r_nxt = qbit ? diff : sh;

endmodule

// File: rtl/rca_div8x4.sv
// Sequential restoring divider, DW-bit dividend by VW-bit divisor.
// Optional DIV_ZERO_DET_EN: zero divisor completes in one cycle.
module rca_div8x4
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic         clk,
  input  logic         rst_n,
  rca_div8x4_if.slave  bus
);

  state_e             state_q, state_d;
  logic [VW:0]        r_q, r_d;
  logic [DW-1:0]      q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]      dvs_q, dvs_d;
  logic [DW-1:0]      quot_q, quot_d;
  logic [VW-1:0]      rem_q, rem_d;
  logic [VW:0]        r_step;
  logic               qbit;
`ifdef DIV_ZERO_DET_EN
  logic               dbz_q, dbz_d;
`endif

  div_step #(.VW(VW)) u_step (
    .r       (r_q),
    .bin     (q_q[DW-1]),
    .divisor (dvs_q),
    .r_nxt   (r_step),
    .qbit    (qbit)
  );

  // FSM next state, datapath and result loads
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_DET_EN
    dbz_d   = dbz_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          dvs_d   = bus.divisor;
          r_d     = '0;
          q_d     = bus.dividend;
          cnt_d   = CNT_W'(DW - 1);
          state_d = RUN;
`ifdef DIV_ZERO_DET_EN
          if (bus.divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.dividend[VW-1:0];
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        r_d = r_step;
        q_d = {q_q[DW-2:0], qbit};
        if (cnt_q == '0) begin
          quot_d  = {q_q[DW-2:0], qbit};
          rem_d   = r_step[VW-1:0];
          state_d = DONE;
`ifdef DIV_ZERO_DET_EN
          dbz_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_DET_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_DET_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
`ifdef DIV_ZERO_DET_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule
